// File: rtl/jt12_kon_wr.sv
// jt12_kon_wr: CPU write decoder and key-on queue for the YM2612/YM2203 core.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   clk_en            chip clock enable; sequencer and busy timing advance on it
//   cs_n, wr_n        CPU chip select / write strobe, active low
//   addr[1:0]         bit0: 0 = address phase, 1 = data phase; bit1: register part
//   din[7:0]          CPU write data
//   next_op, next_ch  current sequencer slot; the last slot of a round is the marker
//   up_keyon          one clk_en cycle strobe when a queued key-on is released
//   keyon_ch/op       channel code and operator mask of the released key-on
//   csm               CSM mode flag from register 0x27
//   busy              write-busy flag, busy_cyc clk_en cycles after a data write
//   kon_ovf           sticky flag: a key-on was dropped on a full queue
module jt12_kon_wr #(
  parameter int num_ch   = 6,
  parameter int depth    = 4,
  parameter int busy_cyc = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  output logic       up_keyon,
  output logic [2:0] keyon_ch,
  output logic [3:0] keyon_op,
  output logic       csm,
  output logic       busy,
  output logic       kon_ovf
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(busy_cyc + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(depth);
  localparam logic [CW-1:0] BUSY_LD  = CW'(busy_cyc);

  logic          strobe;
  logic          strobe_d;
  logic          wr_ev;
  logic          addr_wr;
  logic          data_wr;
  logic [7:0]    reg_num;
  logic          part;
  logic          kon_wr;
  logic          csm_wr;
  logic          entry_ok;
  logic          mark;
  logic          mark_d;
  logic [6:0]    fifo_mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [CW-1:0] busy_cnt;

  // A write is the first clk edge of a low cs_n/wr_n pair, independent of clk_en.
  assign strobe  = ~cs_n & ~wr_n;
  assign wr_ev   = strobe & ~strobe_d;
  assign addr_wr = wr_ev & ~addr[0];
  assign data_wr = wr_ev &  addr[0];
  assign kon_wr  = data_wr & ~part & (reg_num == 8'h28);
  assign csm_wr  = data_wr & ~part & (reg_num == 8'h27);

  // Channel codes 3 and 7 do not exist; YM2203 only has channels 0..2.
  always_comb begin
    entry_ok = (din[1:0] != 2'b11);
    if (num_ch == 3 && din[2:0] > 3'd2) begin
      entry_ok = 1'b0;
    end
  end

  // Marker: last operator slot of the last channel in a round.
  always_comb begin
    if (num_ch == 3) begin
      mark = (next_ch == 3'd2) && (next_op == 2'd3);
    end else begin
      mark = (next_ch == 3'd6) && (next_op == 2'd3);
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = clk_en & mark_d & ~empty;
  // A full queue still accepts an entry when the head leaves on the same edge.
  assign push  = kon_wr & entry_ok & (~full | pop);
  assign drop  = kon_wr & entry_ok & full & ~pop;
  assign busy  = (busy_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {din[7:4], din[2:0]};
    end
  end

  // CPU interface: strobe edge detect and register/part latch.
  // strobe_d resets high so a strobe held across reset is not taken as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_d <= 1'b1;
      reg_num  <= '0;
      part     <= 1'b0;
      csm      <= 1'b0;
    end else begin
      strobe_d <= strobe;
      if (addr_wr) begin
        reg_num <= din;
        part    <= addr[1];
      end
      if (csm_wr) begin
        csm <= (num_ch != 3) && (din[7:6] == 2'b10);
      end
    end
  end

  // Key-on queue pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      kon_ovf <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        kon_ovf <= 1'b1;
      end
    end
  end

  // Release side: one entry per round, on the clk_en cycle after the marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark_d   <= 1'b0;
      up_keyon <= 1'b0;
      keyon_ch <= '0;
      keyon_op <= '0;
    end else if (clk_en) begin
      mark_d   <= mark;
      up_keyon <= pop;
      if (pop) begin
        keyon_ch <= fifo_mem[rd_ptr][2:0];
        keyon_op <= fifo_mem[rd_ptr][6:3];
      end
    end
  end

  // Busy: reload on every data write, count down on clk_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (data_wr) begin
      busy_cnt <= BUSY_LD;
    end else if (clk_en && busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

endmodule
